// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: control sequencer for an N-point radix-2 DIT FFT with ping-pong buffers.
// Runs bit-reversed load, per-stage butterfly issue, drain, buffer swap and natural-order unload.
module fft_seq_ctrl #(
  parameter int LOG2N    = 4,
  parameter int PIPE_LAT = 3,
  parameter int SW       = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inverse,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LOG2N-1:0] load_addr,
  output logic             bf_en,
  output logic [SW-1:0]    stage,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             tw_conj,
  output logic             read_sel,
  output logic             write_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] out_addr,
  output logic             done,
  output logic             busy
);

  localparam int N = 2 ** LOG2N;
  localparam logic [LOG2N-1:0] CNT_ONE     = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST    = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] BF_LAST     = LOG2N'(N / 2 - 1);
  localparam logic [3:0]       DRAIN_LAST  = 4'(PIPE_LAT - 1);
  localparam logic [SW-1:0]    STAGE_ONE   = SW'(1);
  localparam logic [SW-1:0]    STAGE_LAST  = SW'(LOG2N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_SWAP    = 3'd4,
    S_UNLOAD  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [LOG2N-1:0]   cnt_q, cnt_d;
  logic [3:0]         dcnt_q, dcnt_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic               conj_q, conj_d, rsel_q, rsel_d, wsel_q, wsel_d;
  logic               in_ready_q, in_ready_d, bf_en_q, bf_en_d, out_valid_q, out_valid_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic [LOG2N-1:0]   load_addr_q, load_addr_d, out_addr_q, out_addr_d;
  logic [LOG2N-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [LOG2N-2:0]   tw_addr_q, tw_addr_d;
  logic [LOG2N-1:0]   span, pos, grp;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    stage_d = stage_q;
    conj_d  = conj_q;
    rsel_d  = rsel_q;
    wsel_d  = wsel_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dcnt_d  = '0;
      stage_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            conj_d  = inverse;
            cnt_d   = '0;
            dcnt_d  = '0;
            stage_d = '0;
            rsel_d  = 1'b0;
            wsel_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_COMPUTE;
              cnt_d   = '0;
              stage_d = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_COMPUTE: begin
          if (cnt_q == BF_LAST) begin
            cnt_d  = '0;
            dcnt_d = '0;
            if (PIPE_LAT == 0) begin
              state_d = S_SWAP;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DRAIN_LAST) begin
            state_d = S_SWAP;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + 4'd1;
          end
        end
        S_SWAP: begin
          rsel_d = ~rsel_q;
          wsel_d = ~wsel_q;
          cnt_d  = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = S_UNLOAD;
          end else begin
            state_d = S_COMPUTE;
            stage_d = stage_q + STAGE_ONE;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          stage_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dcnt_d  = '0;
          stage_d = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    in_ready_d  = (state_d == S_LOAD);
    bf_en_d     = (state_d == S_COMPUTE);
    out_valid_d = (state_d == S_UNLOAD);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    span        = CNT_ONE << stage_d;
    pos         = cnt_d & (span - CNT_ONE);
    grp         = cnt_d >> stage_d;
    if (state_d == S_COMPUTE) begin
      addr_a_d  = ((grp << stage_d) << 1'b1) | pos;
      addr_b_d  = (((grp << stage_d) << 1'b1) | pos) + span;
      tw_addr_d = (LOG2N-1)'(pos) << (STAGE_LAST - stage_d);
    end else begin
      addr_a_d  = '0;
      addr_b_d  = '0;
      tw_addr_d = '0;
    end
    load_addr_d = (state_d == S_LOAD)   ? bit_rev(cnt_d) : '0;
    out_addr_d  = (state_d == S_UNLOAD) ? cnt_d          : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dcnt_q      <= '0;
      stage_q     <= '0;
      conj_q      <= 1'b0;
      rsel_q      <= 1'b0;
      wsel_q      <= 1'b1;
      in_ready_q  <= 1'b0;
      bf_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      load_addr_q <= '0;
      out_addr_q  <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      tw_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dcnt_q      <= dcnt_d;
      stage_q     <= stage_d;
      conj_q      <= conj_d;
      rsel_q      <= rsel_d;
      wsel_q      <= wsel_d;
      in_ready_q  <= in_ready_d;
      bf_en_q     <= bf_en_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      load_addr_q <= load_addr_d;
      out_addr_q  <= out_addr_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      tw_addr_q   <= tw_addr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign load_addr = load_addr_q;
  assign bf_en     = bf_en_q;
  assign stage     = stage_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign tw_conj   = conj_q;
  assign read_sel  = rsel_q;
  assign write_sel = wsel_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: two instances (PIPE_LAT 3 and 0) share one set of
// expected-event queues; only one instance runs a pass at any time.
module tb_fft_seq_ctrl;

  localparam int L   = 4;
  localparam int N   = 16;
  localparam int PL0 = 3;
  localparam int PL1 = 0;
  localparam int TMO = 3000;

  typedef struct {
    int st;
    int a;
    int b;
    int tw;
    int rs;
  } bf_t;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic inverse [2];
  logic abort [2];
  logic in_valid [2];
  logic out_ready [2];
  logic in_ready [2];
  logic bf_en [2];
  logic tw_conj [2];
  logic read_sel [2];
  logic write_sel [2];
  logic out_valid [2];
  logic done [2];
  logic busy [2];
  logic [L-1:0] load_addr [2];
  logic [L-1:0] addr_a [2];
  logic [L-1:0] addr_b [2];
  logic [L-1:0] out_addr [2];
  logic [1:0]   stage [2];
  logic [L-2:0] tw_addr [2];

  int   checks = 0;
  int   errors = 0;
  int   load_q [$];
  bf_t  bf_q [$];
  int   out_q [$];
  int   done_q [$];
  int   mon_i;
  bf_t  mon_b;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.LOG2N(L), .PIPE_LAT(PL0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .inverse(inverse[0]), .abort(abort[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .load_addr(load_addr[0]),
    .bf_en(bf_en[0]), .stage(stage[0]), .addr_a(addr_a[0]), .addr_b(addr_b[0]),
    .tw_addr(tw_addr[0]), .tw_conj(tw_conj[0]), .read_sel(read_sel[0]),
    .write_sel(write_sel[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_addr(out_addr[0]), .done(done[0]), .busy(busy[0])
  );

  fft_seq_ctrl #(.LOG2N(L), .PIPE_LAT(PL1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .inverse(inverse[1]), .abort(abort[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .load_addr(load_addr[1]),
    .bf_en(bf_en[1]), .stage(stage[1]), .addr_a(addr_a[1]), .addr_b(addr_b[1]),
    .tw_addr(tw_addr[1]), .tw_conj(tw_conj[1]), .read_sel(read_sel[1]),
    .write_sel(write_sel[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_addr(out_addr[1]), .done(done[1]), .busy(busy[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int pl_of(input int d);
    return (d == 0) ? PL0 : PL1;
  endfunction

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < L; b++) begin
      if (((v >> b) % 2) == 1) r = r + 2 ** (L - 1 - b);
    end
    return r;
  endfunction

  // Reference model: the full event sequence of one pass, from the arithmetic definitions.
  task automatic push_model();
    bf_t e;
    int  span;
    for (int i = 0; i < N; i++) load_q.push_back(brev(i));
    for (int s = 0; s < L; s++) begin
      span = 2 ** s;
      for (int k = 0; k < N / 2; k++) begin
        e.st = s;
        e.a  = (k / span) * 2 * span + (k % span);
        e.b  = e.a + span;
        e.tw = (k % span) * ((N / 2) / span);
        e.rs = s % 2;
        bf_q.push_back(e);
      end
    end
    for (int j = 0; j < N; j++) out_q.push_back(j);
    done_q.push_back(1);
  endtask

  task automatic flush();
    load_q.delete();
    bf_q.delete();
    out_q.delete();
    done_q.delete();
  endtask

  // Monitor: pops and compares whenever either instance presents an event.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (in_ready[d] && in_valid[d]) begin
        if (load_q.size() == 0) chk("load_unexpected", 1, 0);
        else begin
          mon_i = load_q.pop_front();
          chk("load_addr", int'(load_addr[d]), mon_i);
          chk("load_read_sel", int'(read_sel[d]), 0);
        end
      end
      if (bf_en[d]) begin
        if (bf_q.size() == 0) chk("bf_unexpected", 1, 0);
        else begin
          mon_b = bf_q.pop_front();
          chk("bf_stage", int'(stage[d]), mon_b.st);
          chk("bf_addr_a", int'(addr_a[d]), mon_b.a);
          chk("bf_addr_b", int'(addr_b[d]), mon_b.b);
          chk("bf_tw_addr", int'(tw_addr[d]), mon_b.tw);
          chk("bf_read_sel", int'(read_sel[d]), mon_b.rs);
          chk("bf_write_sel", int'(write_sel[d]), 1 - mon_b.rs);
        end
      end
      if (out_valid[d] && out_ready[d]) begin
        if (out_q.size() == 0) chk("out_unexpected", 1, 0);
        else begin
          mon_i = out_q.pop_front();
          chk("out_addr", int'(out_addr[d]), mon_i);
          chk("out_read_sel", int'(read_sel[d]), L % 2);
        end
      end
      if (done[d]) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else mon_i = done_q.pop_front();
      end
    end
  end

  task automatic start_pass(input int d, input bit inv);
    push_model();
    inverse[d]   = inv;
    start[d]     = 1'b1;
    in_valid[d]  = 1'b1;
    out_ready[d] = 1'b1;
    tick();
    start[d]   = 1'b0;
    inverse[d] = !inv;
  endtask

  // mode 0: no stalls; mode 1: fixed stalls (5 at i=8, 4 at j=6); mode 2: random stalls.
  task automatic run_pass(input int d, input bit inv, input int mode, input bit retrig);
    int busy_cnt = 0, stalls = 0, xin = 0, xout = 0, in_st = 0, out_st = 0;
    int last_st = -1, last_cyc = 0, guard = 0, idle = 0, base;
    bit conj_bad = 1'b0, rt = 1'b0, iv, ordy;
    base = 2 * N + L * (N / 2 + pl_of(d) + 1) + 1;
    start_pass(d, inv);
    while (busy[d] && guard < TMO) begin
      busy_cnt++;
      if (tw_conj[d] !== inv) conj_bad = 1'b1;
      if (bf_en[d] && int'(stage[d]) != last_st) begin
        if (last_st >= 0) chk("stage_period", busy_cnt - last_cyc, N / 2 + pl_of(d) + 1);
        last_st  = int'(stage[d]);
        last_cyc = busy_cnt;
      end
      iv   = 1'b1;
      ordy = 1'b1;
      if (mode == 1) begin
        if (in_ready[d] && xin == 8 && in_st < 5) begin
          iv = 1'b0;
          in_st++;
        end
        if (out_valid[d] && xout == 6 && out_st < 4) begin
          ordy = 1'b0;
          out_st++;
          chk("out_addr_hold", int'(out_addr[d]), 6);
        end
      end else if (mode == 2) begin
        iv   = ($urandom_range(3) != 0);
        ordy = ($urandom_range(3) != 0);
      end
      if (in_ready[d]) begin
        if (iv) xin++;
        else stalls++;
      end
      if (out_valid[d]) begin
        if (ordy) xout++;
        else stalls++;
      end
      in_valid[d]  = iv;
      out_ready[d] = ordy;
      start[d]     = retrig && ((bf_en[d] && !rt) || done[d]);
      if (bf_en[d]) rt = 1'b1;
      tick();
      guard++;
    end
    start[d]    = 1'b0;
    in_valid[d] = 1'b0;
    chk("pass_timeout", (guard < TMO) ? 1 : 0, 1);
    chk("busy_cycles", busy_cnt, base + stalls);
    if (mode == 1) chk("stall_cycles", stalls, 9);
    chk("tw_conj_held", int'(conj_bad), 0);
    chk("final_read_sel", int'(read_sel[d]), L % 2);
    chk("final_write_sel", int'(write_sel[d]), 1 - L % 2);
    repeat (5) begin
      tick();
      if (busy[d]) idle++;
    end
    chk("no_second_pass", idle, 0);
    chk("queues_drained", load_q.size() + bf_q.size() + out_q.size() + done_q.size(), 0);
  endtask

  task automatic wait_bf(input int d, input int st, input int a, output bit found);
    int g = 0;
    while (!(bf_en[d] && int'(stage[d]) == st && int'(addr_a[d]) == a) && g < TMO) begin
      tick();
      g++;
    end
    found = (g < TMO);
  endtask

  task automatic abort_test();
    bit found;
    int noisy = 0;
    start_pass(0, 1'b0);
    wait_bf(0, 1, 5, found);
    chk("abort_point_found", int'(found), 1);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_bf_en", int'(bf_en[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    flush();
    repeat (20) begin
      tick();
      if (done[0] || busy[0]) noisy++;
    end
    chk("abort_quiet", noisy, 0);
    in_valid[0] = 1'b0;
  endtask

  task automatic reset_test();
    bit found;
    start_pass(0, 1'b1);
    wait_bf(0, 1, 0, found);
    chk("rst_point_found", int'(found), 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy[0]), 0);
    chk("rst_mid_bf_en", int'(bf_en[0]), 0);
    chk("rst_mid_read_sel", int'(read_sel[0]), 0);
    chk("rst_mid_write_sel", int'(write_sel[0]), 1);
    chk("rst_mid_tw_conj", int'(tw_conj[0]), 0);
    tick();
    rst = 1'b1;
    flush();
    in_valid[0] = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start[d]     = 1'b0;
      inverse[d]   = 1'b0;
      abort[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", int'(busy[d]), 0);
      chk("reset_read_sel", int'(read_sel[d]), 0);
      chk("reset_write_sel", int'(write_sel[d]), 1);
      chk("reset_done", int'(done[d]), 0);
      chk("reset_in_ready", int'(in_ready[d]), 0);
    end
    rst = 1'b1;
    tick();
    chk("post_reset_busy", int'(busy[0]), 0);
    chk("post_reset_bf_en", int'(bf_en[0]), 0);

    run_pass(0, 1'b0, 0, 1'b0);
    run_pass(0, 1'b1, 1, 1'b1);
    abort_test();
    run_pass(1, 1'b0, 0, 1'b0);
    reset_test();
    for (int r = 0; r < 6; r++) begin
      run_pass(r % 2, ($urandom_range(1) == 1), 2, ($urandom_range(1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
